draw_enemy: RTL and testbench

DRAW_ENEMY -- requirements
Module: draw_enemy

---
 rtl/draw_enemy_pkg.sv | 36 +++
 rtl/enemy_rom.sv | 40 ++++
 rtl/draw_enemy.sv | 180 ++++++++++++++++++
 tb/tb_draw_enemy.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/draw_enemy_pkg.sv
// ============================================================================
//  Module   : draw_enemy_pkg
//  Purpose  : Shared VGA constants, colour type and timing bundle for draw_enemy.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package draw_enemy_pkg;

    localparam int H_VISIBLE = 800;
    localparam int V_VISIBLE = 600;
    localparam int COLOR_W   = 12;
    localparam int CNT_W     = 11;
    localparam int POS_W     = 12;

    localparam logic [COLOR_W-1:0] KEY_COLOR_DEFAULT = 12'h000;

    typedef logic [COLOR_W-1:0] rgb_t;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_timing_t;

    // Texel generator: solid body with one key-coloured (transparent) hole.
    function automatic rgb_t sprite_texel(input logic is_hole, input rgb_t body, input rgb_t key);
        return is_hole ? key : body;
    endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_rom.sv
// ============================================================================
//  Module   : enemy_rom
//  Purpose  : Enemy sprite store, synchronous read with 1-cycle latency.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module enemy_rom
    import draw_enemy_pkg::*;
#(
    parameter int   WIDTH      = 32,
    parameter int   HEIGHT     = 32,
    parameter int   ADDR_W     = $clog2(WIDTH) + $clog2(HEIGHT),
    parameter rgb_t BODY_COLOR = 12'hF00,
    parameter rgb_t KEY_COLOR  = KEY_COLOR_DEFAULT
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output rgb_t              data
);

    // Address layout is {row, col}, so row*WIDTH+col selects the centre texel.
    localparam logic [ADDR_W-1:0] c_HOLE_ADDR = ADDR_W'((HEIGHT / 2) * WIDTH + (WIDTH / 2));

    rgb_t r_data_q;
    rgb_t w_data_d;

    always_comb begin
        w_data_d = sprite_texel(addr == c_HOLE_ADDR, BODY_COLOR, KEY_COLOR);
    end

    always_ff @(posedge clk) begin
        r_data_q <= w_data_d;
    end

    assign data = r_data_q;

endmodule

`default_nettype wire

// File: rtl/draw_enemy.sv
// ============================================================================
//  Module   : draw_enemy
//  Purpose  : Composites a frame-latched enemy sprite over the VGA stream
//             (2-cycle latency). Optional ENEMY_HIT_EN adds hit_in/dead.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module draw_enemy
    import draw_enemy_pkg::*;
#(
    parameter int   WIDTH     = 32,
    parameter int   HEIGHT    = 32,
    parameter rgb_t KEY_COLOR = KEY_COLOR_DEFAULT
) (
    input  logic             pclk,
    input  logic             rst,
`ifdef ENEMY_HIT_EN
    input  logic             hit_in,
    output logic             dead,
`endif
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  rgb_t             rgb_in,
    input  logic [POS_W-1:0] xpos,
    input  logic [POS_W-1:0] ypos,
    input  logic             on,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output rgb_t             rgb_out
);

    localparam int c_COL_W  = $clog2(WIDTH);
    localparam int c_ROW_W  = $clog2(HEIGHT);
    localparam int c_ADDR_W = c_COL_W + c_ROW_W;

    logic             r_vblnk_prev_q;
    logic [POS_W-1:0] r_x_q, w_x_d, r_y_q, w_y_d;
    logic             r_on_q, w_on_d;
    logic             w_vblnk_rise;
    logic             w_dead_mask;

    vga_timing_t      w_tim_in, r_tim1_q, r_tim2_q;
    rgb_t             r_rgb1_q, r_rgb2_q, w_rgb2_d;
    logic             r_inside_q, w_inside_d;

    logic [12:0]        w_h13, w_v13, w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic               w_in_h, w_in_v;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    rgb_t               w_rom_data;

    // Position/visibility only change at the start of vertical blanking.
    always_comb begin
        w_vblnk_rise = vblnk_in & ~r_vblnk_prev_q;
        w_x_d        = w_vblnk_rise ? xpos : r_x_q;
        w_y_d        = w_vblnk_rise ? ypos : r_y_q;
        w_on_d       = w_vblnk_rise ? on   : r_on_q;
    end

`ifdef ENEMY_HIT_EN
    logic r_dead_q, w_dead_d;
    logic r_on_prev_q, r_on_rose_q, w_on_rose_d, w_on_rise;

    always_comb begin
        w_on_rise   = on & ~r_on_prev_q;
        w_dead_d    = r_dead_q;
        w_on_rose_d = r_on_rose_q;
        if (hit_in && r_on_q) begin
            w_dead_d = 1'b1;
        end else if (w_vblnk_rise && (r_on_rose_q || w_on_rise)) begin
            w_dead_d = 1'b0;
        end
        if (w_vblnk_rise) begin
            w_on_rose_d = 1'b0;
        end else if (w_on_rise) begin
            w_on_rose_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_dead_q    <= 1'b0;
            r_on_prev_q <= 1'b0;
            r_on_rose_q <= 1'b0;
        end else begin
            r_dead_q    <= w_dead_d;
            r_on_prev_q <= on;
            r_on_rose_q <= w_on_rose_d;
        end
    end

    assign dead        = r_dead_q;
    assign w_dead_mask = r_dead_q;
`else
    assign w_dead_mask = 1'b0;
`endif

    // 13-bit compares keep x+WIDTH-1 from wrapping back to column/row 0.
    always_comb begin
        w_h13      = {2'b00, hcount_in};
        w_v13      = {2'b00, vcount_in};
        w_x_lo     = {1'b0, r_x_q};
        w_y_lo     = {1'b0, r_y_q};
        w_x_hi     = w_x_lo + 13'(WIDTH - 1);
        w_y_hi     = w_y_lo + 13'(HEIGHT - 1);
        w_in_h     = (w_h13 >= w_x_lo) && (w_h13 <= w_x_hi) && (hcount_in < CNT_W'(H_VISIBLE));
        w_in_v     = (w_v13 >= w_y_lo) && (w_v13 <= w_y_hi) && (vcount_in < CNT_W'(V_VISIBLE));
        w_inside_d = r_on_q && w_in_h && w_in_v && !w_dead_mask;
        w_col      = c_COL_W'(hcount_in) - c_COL_W'(r_x_q);
        w_row      = c_ROW_W'(vcount_in) - c_ROW_W'(r_y_q);
        w_tim_in   = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
    end

    enemy_rom #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .ADDR_W    (c_ADDR_W),
        .BODY_COLOR(12'hF00),
        .KEY_COLOR (KEY_COLOR)
    ) u_rom (
        .clk (pclk),
        .addr({w_row, w_col}),
        .data(w_rom_data)
    );

    always_comb begin
        w_rgb2_d = r_rgb1_q;
        if (r_inside_q && (w_rom_data != KEY_COLOR)) begin
            w_rgb2_d = w_rom_data;
        end
        if (r_tim1_q.hblnk || r_tim1_q.vblnk) begin
            w_rgb2_d = '0;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_vblnk_prev_q <= 1'b0;
            r_x_q          <= '0;
            r_y_q          <= '0;
            r_on_q         <= 1'b0;
            r_tim1_q       <= '0;
            r_tim2_q       <= '0;
            r_rgb1_q       <= '0;
            r_rgb2_q       <= '0;
            r_inside_q     <= 1'b0;
        end else begin
            r_vblnk_prev_q <= vblnk_in;
            r_x_q          <= w_x_d;
            r_y_q          <= w_y_d;
            r_on_q         <= w_on_d;
            r_tim1_q       <= w_tim_in;
            r_tim2_q       <= r_tim1_q;
            r_rgb1_q       <= rgb_in;
            r_rgb2_q       <= w_rgb2_d;
            r_inside_q     <= w_inside_d;
        end
    end

    assign hcount_out = r_tim2_q.hcount;
    assign vcount_out = r_tim2_q.vcount;
    assign hsync_out  = r_tim2_q.hsync;
    assign vsync_out  = r_tim2_q.vsync;
    assign hblnk_out  = r_tim2_q.hblnk;
    assign vblnk_out  = r_tim2_q.vblnk;
    assign rgb_out    = r_rgb2_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_enemy.sv
// ============================================================================
//  Module   : tb_draw_enemy
//  Purpose  : Directed self-checking bench for draw_enemy (32x32 sprite, solid
//             12'hF00 body with a key-colour hole at texel row 16, col 16).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_draw_enemy;

    logic        pclk;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] xpos, ypos;
    logic        on;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
`ifdef ENEMY_HIT_EN
    logic        hit_in;
    logic        dead;
`endif

    int n_pass  = 0;
    int n_total = 0;

    draw_enemy dut (
        .pclk      (pclk),
        .rst       (rst),
`ifdef ENEMY_HIT_EN
        .hit_in    (hit_in),
        .dead      (dead),
`endif
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hblnk_in  (hblnk_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .xpos      (xpos),
        .ypos      (ypos),
        .on        (on),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .hblnk_out (hblnk_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one active-video pixel for two cycles, then check its composite.
    task automatic pixel(input string tag, input int h, input int v,
                         input logic [11:0] bg, input logic [11:0] exp);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        rgb_in    = bg;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        step();
        step();
        chk(tag, 48'(rgb_out), 48'(exp));
    endtask

    task automatic vblank_pulse();
        hcount_in = 11'd0;
        vcount_in = 11'd600;
        rgb_in    = 12'hABC;
        vblnk_in  = 1'b1;
        hblnk_in  = 1'b1;
        repeat (3) step();
        vblnk_in  = 1'b0;
        hblnk_in  = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        hcount_in = 11'd5; vcount_in = 11'd7;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hF0F; xpos = 12'd100; ypos = 12'd50; on = 1'b1;
`ifdef ENEMY_HIT_EN
        hit_in = 1'b0;
`endif
        // Reset held 5 cycles with busy inputs: everything stays cleared.
        repeat (5) step();
        chk("reset_timing", 48'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 48'd0);
        chk("reset_rgb", 48'(rgb_out), 48'd0);
        rst = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;

        // Before the first vblank the sprite is hidden even though on=1.
        pixel("hidden_before_vblank", 110, 60, 12'h123, 12'h123);

        // Latency: hsync pulse at N appears at N+2 with aligned rgb/counters.
        hcount_in = 11'd10; vcount_in = 11'd10; rgb_in = 12'h0F0; hsync_in = 1'b1;
        step();
        chk("hsync_n1", 48'(hsync_out), 48'd0);
        hsync_in = 1'b0;
        step();
        chk("hsync_n2", 48'(hsync_out), 48'd1);
        chk("rgb_n2", 48'(rgb_out), 48'h0F0);
        chk("hcount_n2", 48'(hcount_out), 48'd10);
        step();
        chk("hsync_n3", 48'(hsync_out), 48'd0);

        // Blanking forces black; latch xpos=100, ypos=50, on=1.
        hcount_in = 11'd0; vcount_in = 11'd600; rgb_in = 12'hABC;
        vblnk_in = 1'b1; hblnk_in = 1'b1;
        repeat (3) step();
        chk("blank_rgb", 48'(rgb_out), 48'd0);
        chk("blank_vblnk_out", 48'(vblnk_out), 48'd1);
        vblnk_in = 1'b0; hblnk_in = 1'b0;
        step();

        // Placement: corners in, one-pixel neighbours out, centre hole transparent.
        pixel("place_100_50", 100, 50, 12'h00F, 12'hF00);
        pixel("place_131_50", 131, 50, 12'h00F, 12'hF00);
        pixel("place_100_81", 100, 81, 12'h00F, 12'hF00);
        pixel("place_131_81", 131, 81, 12'h00F, 12'hF00);
        pixel("place_99_50", 99, 50, 12'h00F, 12'h00F);
        pixel("place_132_50", 132, 50, 12'h00F, 12'h00F);
        pixel("place_100_49", 100, 49, 12'h00F, 12'h00F);
        pixel("place_100_82", 100, 82, 12'h00F, 12'h00F);
        pixel("key_hole_116_66", 116, 66, 12'h0A5, 12'h0A5);

        // Latching: mid-frame move is ignored until the next vblank rise.
        xpos = 12'd300;
        pixel("latch_old_pos", 100, 50, 12'h00F, 12'hF00);
        pixel("latch_new_not_yet", 300, 50, 12'h00F, 12'h00F);
        vblank_pulse();
        pixel("latch_new_pos", 300, 50, 12'h00F, 12'hF00);
        pixel("latch_old_gone", 100, 50, 12'h00F, 12'h00F);

        // Clipping at the right edge, no wrap to low columns.
        xpos = 12'd780;
        vblank_pulse();
        pixel("clip_780", 780, 50, 12'h00F, 12'hF00);
        pixel("clip_799", 799, 50, 12'h00F, 12'hF00);
        pixel("clip_no_wrap_0", 0, 50, 12'h00F, 12'h00F);
        pixel("clip_no_wrap_11", 11, 50, 12'h00F, 12'h00F);

        // on falling mid-frame keeps the sprite until the next vblank.
        on = 1'b0;
        pixel("on_fall_still_drawn", 785, 60, 12'h00F, 12'hF00);
        vblank_pulse();
        pixel("on_fall_hidden", 785, 60, 12'h00F, 12'h00F);

        // Asynchronous reset mid-frame clears output immediately and hides sprite.
        on = 1'b1;
        vblank_pulse();
        pixel("pre_reset_drawn", 785, 60, 12'h00F, 12'hF00);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_rgb", 48'(rgb_out), 48'd0);
        chk("async_reset_hcount", 48'(hcount_out), 48'd0);
        step();
        rst = 1'b1;
        pixel("post_reset_hidden", 785, 60, 12'h00F, 12'h00F);

`ifdef ENEMY_HIT_EN
        xpos = 12'd100; ypos = 12'd50; on = 1'b1;
        vblank_pulse();
        chk("dead_initial", 48'(dead), 48'd0);
        hcount_in = 11'd110; vcount_in = 11'd60; rgb_in = 12'h00F; hit_in = 1'b1;
        step();
        hit_in = 1'b0;
        chk("dead_after_hit", 48'(dead), 48'd1);
        pixel("dead_sprite_gone", 112, 60, 12'h00F, 12'h00F);
        on = 1'b0;
        vblank_pulse();
        chk("dead_holds", 48'(dead), 48'd1);
        on = 1'b1;
        vblank_pulse();
        chk("dead_cleared", 48'(dead), 48'd0);
        pixel("revived_sprite", 112, 60, 12'h00F, 12'hF00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
